// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port round-robin arbiter in front of one SRAM controller (ARB_FIXED_PRIO_EN selects fixed port-0 priority)
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_r_en,
  input  logic              p0_w_en,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic              p1_r_en,
  input  logic              p1_w_en,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_done,
  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_t;
  state_t state;
  logic   req0, req1, win, w_sel, r_sel;
  assign req0 = p0_r_en | p0_w_en;
  assign req1 = p1_r_en | p1_w_en;
`ifdef ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  logic last;
  assign win = req1 & (~req0 | ~last);
`endif
  assign w_sel = win ? p1_w_en : p0_w_en;
  assign r_sel = win ? p1_r_en : p0_r_en;
  // Arbitration FSM: latch the winner in IDLE, hold it until sram_done, pulse done in RELEASE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      sram_r_en  <= 1'b0;
      sram_w_en  <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      grant      <= 2'b00;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          state      <= win ? BUSY1 : BUSY0;
`ifndef ARB_FIXED_PRIO_EN
          last       <= win;
`endif
          sram_addr  <= win ? p1_addr : p0_addr;
          sram_wdata <= win ? p1_wdata : p0_wdata;
          sram_w_en  <= w_sel;
          sram_r_en  <= r_sel & ~w_sel;
          grant      <= win ? 2'b10 : 2'b01;
        end
        BUSY0, BUSY1: if (sram_done) begin
          state     <= RELEASE;
          sram_r_en <= 1'b0;
          sram_w_en <= 1'b0;
          grant     <= 2'b00;
          p0_done   <= state == BUSY0;
          p1_done   <= state == BUSY1;
          if (sram_r_en && state == BUSY0) p0_rdata <= sram_rdata;
          if (sram_r_en && state == BUSY1) p1_rdata <= sram_rdata;
        end
        RELEASE: begin
          state   <= IDLE;
          p0_done <= 1'b0;
          p1_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_r_en, p0_w_en, p1_r_en, p1_w_en;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_done, p1_done;
  logic        sram_r_en, sram_w_en, sram_done;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [1:0]  grant;
  int          passed = 0;
  int          total = 0;
  logic [31:0] p0_exp, p1_exp;
  logic [1:0]  g_exp;
  always #5 clk = ~clk;
  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_r_en(p0_r_en), .p0_w_en(p0_w_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done),
    .p1_r_en(p1_r_en), .p1_w_en(p1_w_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_done(sram_done),
    .grant(grant)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic complete(input logic [31:0] data);
    sram_rdata = data;
    sram_done  = 1'b1;
    @(negedge clk);
    sram_done  = 1'b0;
  endtask
  initial begin
    rst = 1'b0;
    {p0_r_en, p0_w_en, p1_r_en, p1_w_en, sram_done} = '0;
    {p0_addr, p0_wdata, p1_addr, p1_wdata, sram_rdata} = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_sram_en", {sram_r_en, sram_w_en}, 2'b00);
    check("rst_done", {p0_done, p1_done}, 2'b00);
    check("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    p0_r_en = 1'b1;
    p0_addr = 32'h10;
    rst = 1'b1;
    @(negedge clk);
    check("t1_grant", grant, 2'b01);
    check("t1_sram_en", {sram_r_en, sram_w_en}, 2'b10);
    check("t1_addr", sram_addr, 32'h10);
    complete(32'hDEADBEEF);
    check("t1_done", {p0_done, p1_done}, 2'b10);
    check("t1_rdata", p0_rdata, 32'hDEADBEEF);
    check("t1_grant_rel", grant, 2'b00);
    p0_exp = 32'hDEADBEEF;
    p1_exp = 32'h0;
    p0_r_en = 1'b0;
    @(negedge clk);
    check("t1_done_clr", {p0_done, p1_done}, 2'b00);
    p0_w_en = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h11111111;
    p1_r_en = 1'b1; p1_addr = 32'h24;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      g_exp = 2'b01;
`else
      g_exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
      check($sformatf("t2_grant%0d", i), grant, g_exp);
      check($sformatf("t2_en%0d", i), {sram_r_en, sram_w_en}, g_exp == 2'b01 ? 2'b01 : 2'b10);
      check($sformatf("t2_addr%0d", i), sram_addr, g_exp == 2'b01 ? 32'h20 : 32'h24);
      complete(32'hA0 + i);
      if (g_exp == 2'b10) p1_exp = 32'hA0 + i;
      check($sformatf("t2_done%0d", i), {p0_done, p1_done}, g_exp == 2'b01 ? 2'b10 : 2'b01);
      check($sformatf("t2_rdata%0d", i), {p0_rdata, p1_rdata}, {p0_exp, p1_exp});
      if (i == 3) {p0_w_en, p1_r_en} = 2'b00;
      @(negedge clk);
      if (i < 3) @(negedge clk);
    end
    p1_r_en = 1'b1; p1_w_en = 1'b1; p1_addr = 32'h30; p1_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    check("t3_grant", grant, 2'b10);
    check("t3_en", {sram_r_en, sram_w_en}, 2'b01);
    check("t3_wdata", sram_wdata, 32'h5A5A5A5A);
    complete(32'hBAD0BAD0);
    check("t3_done", {p0_done, p1_done}, 2'b01);
    check("t3_rdata", p1_rdata, p1_exp);
    {p1_r_en, p1_w_en} = 2'b00;
    @(negedge clk);
    p0_r_en = 1'b1; p0_addr = 32'h40;
    @(negedge clk);
    p0_addr = 32'h99;
    p1_r_en = 1'b1; p1_addr = 32'h44;
    @(negedge clk);
    check("t4_addr_hold", sram_addr, 32'h40);
    check("t4_grant", grant, 2'b01);
    complete(32'h1234);
    check("t4_done", {p0_done, p1_done}, 2'b10);
    check("t4_rdata", p0_rdata, 32'h1234);
    p0_r_en = 1'b0;
    @(negedge clk);
    check("t4_idle_grant", grant, 2'b00);
    @(negedge clk);
    check("t4_grant1", grant, 2'b10);
    check("t4_addr1", sram_addr, 32'h44);
    rst = 1'b0;
    #1;
    check("t5_grant", grant, 2'b00);
    check("t5_en", {sram_r_en, sram_w_en}, 2'b00);
    check("t5_done", {p0_done, p1_done}, 2'b00);
    check("t5_rdata", {p0_rdata, p1_rdata}, 64'h0);
    p0_r_en = 1'b1; p0_addr = 32'h50;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_tie_grant", grant, 2'b01);
    check("t5_no_p1_done", p1_done, 1'b0);
    complete(32'h77);
    check("t5_done0", {p0_done, p1_done}, 2'b10);
    {p0_r_en, p1_r_en} = 2'b00;
    @(negedge clk);
    complete(32'h55);
    check("t6_grant", grant, 2'b00);
    check("t6_done", {p0_done, p1_done}, 2'b00);
    check("t6_rdata", {p0_rdata, p1_rdata}, {32'h77, 32'h0});
    @(negedge clk);
    check("t6_done2", {p0_done, p1_done}, 2'b00);
    check("t6_en", {sram_r_en, sram_w_en}, 2'b00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
